oclib_bc_arbiter: RTL and testbench

- Merges the upstream (response) byte streams from up to Inputs BC children into one BC stream toward the parent.
- Replaces the plain OR-merge on the reverse path of the BC tree.
- Arbitration is round-robin and message-atomic: once a child is granted, its whole length-framed message passes before the grant moves.
- A per-message stall timeout and status outputs let the tree recover from a child that stops mid-message.

---
 rtl/oclib_bc_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_oclib_bc_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/oclib_bc_arbiter.sv
// Shared BC channel types and the reset conditioner used by the arbiter.
// The conditioner passes reset straight through when sync and pipeline stages are both zero.
package oclib_pkg;
    localparam bit False = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ready;
    } bc_8b_bidi_s;
endpackage

// Optional reset synchroniser followed by optional reset pipeline.
// Latency SyncCycles+ResetPipeline when ResetSync is set; otherwise ResetPipeline cycles.
module oclib_module_reset #(
    parameter bit ResetSync     = 1'b0,
    parameter int SyncCycles    = 0,
    parameter int ResetPipeline = 0
) (
    input  logic clock,
    input  logic resetIn,
    output logic resetOut
);
    logic synced;
    logic unusedClock;

    assign unusedClock = clock;

    if (ResetSync && SyncCycles > 0) begin : gSync
        logic [SyncCycles-1:0] syncQ;
        always_ff @(posedge clock) begin
            syncQ[0] <= resetIn;
            for (int i = 1; i < SyncCycles; i++) syncQ[i] <= syncQ[i-1];
        end
        assign synced = syncQ[SyncCycles-1];
    end else begin : gNoSync
        assign synced = resetIn;
    end

    if (ResetPipeline > 0) begin : gPipe
        logic [ResetPipeline-1:0] pipeQ;
        always_ff @(posedge clock) begin
            pipeQ[0] <= synced;
            for (int i = 1; i < ResetPipeline; i++) pipeQ[i] <= pipeQ[i-1];
        end
        assign resetOut = pipeQ[ResetPipeline-1];
    end else begin : gNoPipe
        assign resetOut = synced;
    end
endmodule

// Round-robin, message-atomic merge of child BC streams; one arbitration cycle, then 1 byte/cycle.
// Accepted byte is registered (T+1); child ready drops while the output holds a byte the parent refuses.
module oclib_bc_arbiter #(
    parameter type BcType        = oclib_pkg::bc_8b_bidi_s,
    parameter int  Inputs        = 8,
    parameter int  SyncThreshold = 120,
    parameter int  TimeoutCycles = 0,
    parameter bit  ResetSync     = oclib_pkg::False,
    parameter int  SyncCycles    = 0,
    parameter int  ResetPipeline = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  BcType             reqIn [Inputs],
    output BcType             reqOut [Inputs],
    output BcType             arbOut,
    input  BcType             arbIn,
    output logic [Inputs-1:0] grant,
    output logic              busy,
    output logic              timeoutError
);
    localparam int IdxW   = (Inputs > 1) ? $clog2(Inputs) : 1;
    localparam int CntW   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam int ToLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

    typedef enum logic [1:0] {StIdle, StLength, StBody} stateT;

    logic              resetSync;
    stateT             state, stateNext;
    logic [Inputs-1:0] grantNext;
    logic              busyNext, timeoutNext, endMsg;
    logic [7:0]        remaining, remainingNext;
    logic [CntW-1:0]   idleCount, idleNext;
    logic [IdxW-1:0]   rrPtr, rrNext, gIdx, pickIdx;
    logic              found, active, canLoad, selValid, accept;
    logic [7:0]        selData;
    logic              outValid;
    logic [7:0]        outData;
    int                pos;
    logic              unusedBits;

    oclib_module_reset #(
        .ResetSync    (ResetSync),
        .SyncCycles   (SyncCycles),
        .ResetPipeline(ResetPipeline)
    ) uReset (
        .clock   (clock),
        .resetIn (reset),
        .resetOut(resetSync)
    );

    always_comb begin
        gIdx = '0;
        for (int i = 0; i < Inputs; i++) if (grant[i]) gIdx = IdxW'(i);
    end

    // Search starts just past the last owner so a finishing child yields to any other requester.
    always_comb begin
        found   = 1'b0;
        pickIdx = '0;
        pos     = 0;
        for (int k = 1; k <= Inputs; k++) begin
            pos = (int'(rrPtr) + k) % Inputs;
            if (!found && reqIn[pos].valid) begin
                found   = 1'b1;
                pickIdx = IdxW'(pos);
            end
        end
    end

    assign active   = (state != StIdle);
    assign canLoad  = !outValid || arbIn.ready;
    assign selValid = reqIn[gIdx].valid;
    assign selData  = reqIn[gIdx].data;
    assign accept   = active && canLoad && selValid;

    always_comb begin
        for (int i = 0; i < Inputs; i++) begin
            reqOut[i]       = '0;
            reqOut[i].ready = grant[i] && active && canLoad;
        end
        arbOut       = '0;
        arbOut.valid = outValid;
        arbOut.data  = outData;
    end

    always_comb begin
        unusedBits = arbIn.valid ^ (^arbIn.data);
        for (int i = 0; i < Inputs; i++) unusedBits = unusedBits ^ reqIn[i].ready;
    end

    always_comb begin
        stateNext     = state;
        grantNext     = grant;
        busyNext      = busy;
        remainingNext = remaining;
        idleNext      = idleCount;
        rrNext        = rrPtr;
        timeoutNext   = timeoutError;
        endMsg        = 1'b0;
        case (state)
            StIdle: begin
                if (found) begin
                    grantNext          = '0;
                    grantNext[pickIdx] = 1'b1;
                    busyNext           = 1'b1;
                    stateNext          = StLength;
                end
            end
            StLength: begin
                if (accept) begin
                    if (selData == 8'd0 || int'(selData) >= SyncThreshold) begin
                        endMsg = 1'b1;
                    end else begin
                        remainingNext = selData;
                        stateNext     = StBody;
                    end
                end
            end
            StBody: begin
                if (accept) begin
                    remainingNext = remaining - 8'd1;
                    if (remaining == 8'd1) endMsg = 1'b1;
                end
            end
            default: stateNext = StIdle;
        endcase

        // Only a silent child counts toward the stall limit; a refusing parent does not.
        if (active) begin
            if (accept) begin
                idleNext = '0;
            end else if (TimeoutCycles > 0 && canLoad && !selValid) begin
                if (idleCount == CntW'(ToLast)) begin
                    timeoutNext = 1'b1;
                    endMsg      = 1'b1;
                end else begin
                    idleNext = idleCount + 1'b1;
                end
            end
        end

        if (endMsg) begin
            stateNext     = StIdle;
            grantNext     = '0;
            busyNext      = 1'b0;
            remainingNext = '0;
            idleNext      = '0;
            rrNext        = gIdx;
        end
    end

    always_ff @(posedge clock) begin
        if (resetSync) begin
            state        <= StIdle;
            grant        <= '0;
            busy         <= 1'b0;
            timeoutError <= 1'b0;
            remaining    <= '0;
            idleCount    <= '0;
            rrPtr        <= IdxW'(Inputs - 1);
            outValid     <= 1'b0;
            outData      <= '0;
        end else begin
            state        <= stateNext;
            grant        <= grantNext;
            busy         <= busyNext;
            timeoutError <= timeoutNext;
            remaining    <= remainingNext;
            idleCount    <= idleNext;
            rrPtr        <= rrNext;
            if (accept) begin
                outValid <= 1'b1;
                outData  <= selData;
            end else if (arbIn.ready) begin
                outValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_oclib_bc_arbiter.sv
// Bench for oclib_bc_arbiter: child queue models feed the DUT, an expected-byte scoreboard checks the merged stream.
module tb_oclib_bc_arbiter;
    localparam int N = 8;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    oclib_pkg::bc_8b_bidi_s reqIn [N];
    oclib_pkg::bc_8b_bidi_s reqOut [N];
    oclib_pkg::bc_8b_bidi_s arbOut;
    oclib_pkg::bc_8b_bidi_s arbIn;
    logic [N-1:0]           grant;
    logic                   busy;
    logic                   timeoutError;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] childQ [N][$];
    logic [7:0] expQ [$];
    logic [N-1:0] acc;
    int         bpCnt = 0;
    bit         bpOn = 1'b0;

    always #5 clock = ~clock;

    oclib_bc_arbiter #(.Inputs(N), .TimeoutCycles(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .reqIn       (reqIn),
        .reqOut      (reqOut),
        .arbOut      (arbOut),
        .arbIn       (arbIn),
        .grant       (grant),
        .busy        (busy),
        .timeoutError(timeoutError)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit anyPending();
        for (int i = 0; i < N; i++) if (childQ[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic sendMsg(input int ch, input int len, input logic [7:0] base);
        childQ[ch].push_back(8'(len));
        expQ.push_back(8'(len));
        for (int k = 0; k < len; k++) begin
            childQ[ch].push_back(base + 8'(k));
            expQ.push_back(base + 8'(k));
        end
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while ((expQ.size() != 0 || busy || anyPending()) && n < 300) begin
            @(negedge clock);
            n++;
        end
        checkVal(tag, 32'(n < 300), 32'd1);
        repeat (3) @(negedge clock);
    endtask

    task automatic doReset();
        @(posedge clock); #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    // Child models: a byte leaves its queue only when the DUT took it at the edge.
    initial begin
        arbIn = '0;
        for (int i = 0; i < N; i++) reqIn[i] = '0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < N; i++) acc[i] = !reset && reqIn[i].valid && reqOut[i].ready;
            @(posedge clock); #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && childQ[i].size() > 0) void'(childQ[i].pop_front());
                reqIn[i].valid = (childQ[i].size() > 0);
                reqIn[i].data  = (childQ[i].size() > 0) ? childQ[i][0] : 8'h00;
            end
            bpCnt++;
            arbIn.ready = bpOn ? ((bpCnt % 4 == 0) || (bpCnt % 4 == 3)) : 1'b1;
        end
    end

    // Output monitor: scoreboard plus per-cycle handshake invariants.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (arbOut.valid && arbIn.ready) begin
                if (expQ.size() == 0) begin
                    checkVal("extra_byte", 32'(expQ.size()), 32'd1);
                end else begin
                    e = expQ.pop_front();
                    checkVal("stream", 32'(arbOut.data), 32'(e));
                end
            end
            checkVal("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            checkVal("busy_vs_grant", 32'(busy), 32'(|grant));
            for (int i = 0; i < N; i++) begin
                if (arbOut.valid && !arbIn.ready) checkVal("bp_ready", 32'(reqOut[i].ready), 32'd0);
                if (reqOut[i].ready) checkVal("ready_granted", 32'(grant[i]), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkVal("rst_valid", 32'(arbOut.valid), 32'd0);
        checkVal("rst_data", 32'(arbOut.data), 32'd0);
        checkVal("rst_grant", 32'(grant), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_timeout", 32'(timeoutError), 32'd0);
        for (int i = 0; i < N; i++) checkVal("rst_ready", 32'(reqOut[i].ready), 32'd0);
        @(posedge clock); #2 reset = 1'b0;

        // Single source with exact cycle timing.
        @(posedge clock); #2;
        sendMsg(2, 3, 8'h0A);
        @(posedge clock);
        @(negedge clock); checkVal("t1_grant_pre", 32'(grant), 32'h00);
        @(negedge clock); checkVal("t1_grant_arb", 32'(grant), 32'h04);
                          checkVal("t1_valid_arb", 32'(arbOut.valid), 32'd0);
        @(negedge clock); checkVal("t1_b0", 32'({arbOut.valid, arbOut.data}), 32'h103);
        @(negedge clock); checkVal("t1_b1", 32'({arbOut.valid, arbOut.data}), 32'h10A);
        @(negedge clock); checkVal("t1_b2", 32'({arbOut.valid, arbOut.data}), 32'h10B);
                          checkVal("t1_grant_mid", 32'(grant), 32'h04);
        @(negedge clock); checkVal("t1_b3", 32'({arbOut.valid, arbOut.data}), 32'h10C);
                          checkVal("t1_grant_end", 32'(grant), 32'h00);
        @(negedge clock); checkVal("t1_valid_after", 32'(arbOut.valid), 32'd0);
        waitDrain("t1_drain");

        // Contention from a fresh reset, twice.
        doReset();
        for (int r = 0; r < 2; r++) begin
            sendMsg(0, 1, 8'h20 + 8'(r * 8));
            sendMsg(1, 1, 8'h21 + 8'(r * 8));
            sendMsg(5, 1, 8'h25 + 8'(r * 8));
            waitDrain("cont_drain");
        end

        // Backpressure during a 6-byte message.
        bpOn = 1'b1;
        sendMsg(6, 5, 8'h60);
        waitDrain("bp_drain");
        bpOn = 1'b0;
        repeat (2) @(posedge clock);
        #2;

        // Tokens: 0x7E and 0x00 are separate messages; input 4 slips in between.
        childQ[3].push_back(8'h7E); childQ[3].push_back(8'h00);
        childQ[4].push_back(8'h01); childQ[4].push_back(8'h44);
        expQ.push_back(8'h7E); expQ.push_back(8'h01); expQ.push_back(8'h44); expQ.push_back(8'h00);
        waitDrain("tok_drain");

        // Timeout: input 1 stalls after two body bytes.
        @(posedge clock); #2;
        childQ[1].push_back(8'h05); childQ[1].push_back(8'hA1); childQ[1].push_back(8'hA2);
        expQ.push_back(8'h05); expQ.push_back(8'hA1); expQ.push_back(8'hA2);
        n = 0;
        while (grant != 8'h02 && n < 20) begin @(negedge clock); n++; end
        checkVal("to_granted", 32'(grant), 32'h02);
        childQ[4].push_back(8'h01); childQ[4].push_back(8'h4A);
        expQ.push_back(8'h01); expQ.push_back(8'h4A);
        n = 0;
        while (!(reqIn[1].valid && reqOut[1].ready && reqIn[1].data == 8'hA2) && n < 50) begin
            @(negedge clock); n++;
        end
        checkVal("to_last_seen", 32'(n < 50), 32'd1);
        @(posedge clock);
        repeat (16) @(negedge clock);
        checkVal("to_grant_hold", 32'(grant), 32'h02);
        checkVal("to_err_early", 32'(timeoutError), 32'd0);
        @(negedge clock);
        checkVal("to_grant_drop", 32'(grant), 32'h00);
        checkVal("to_err_set", 32'(timeoutError), 32'd1);
        waitDrain("to_drain");
        checkVal("to_err_sticky", 32'(timeoutError), 32'd1);

        // Reset mid-message after two of five body bytes.
        @(posedge clock); #2;
        childQ[2].push_back(8'h05);
        for (int k = 1; k <= 5; k++) childQ[2].push_back(8'hC0 + 8'(k));
        expQ.push_back(8'h05); expQ.push_back(8'hC1); expQ.push_back(8'hC2);
        n = 0;
        while (!(reqIn[2].valid && reqOut[2].ready && reqIn[2].data == 8'hC2) && n < 50) begin
            @(negedge clock); n++;
        end
        checkVal("rm_c2_seen", 32'(n < 50), 32'd1);
        @(posedge clock); #2;
        reset = 1'b1;
        childQ[2].delete();
        @(negedge clock);
        @(negedge clock);
        checkVal("rm_valid", 32'(arbOut.valid), 32'd0);
        checkVal("rm_grant", 32'(grant), 32'h00);
        checkVal("rm_busy", 32'(busy), 32'd0);
        checkVal("rm_err_clr", 32'(timeoutError), 32'd0);
        childQ[3].push_back(8'h01); childQ[3].push_back(8'h33);
        childQ[0].push_back(8'h01); childQ[0].push_back(8'h30);
        expQ.push_back(8'h01); expQ.push_back(8'h30); expQ.push_back(8'h01); expQ.push_back(8'h33);
        @(posedge clock); #2 reset = 1'b0;
        waitDrain("rm_drain");

        checkVal("exp_empty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
